// File: rtl/timing_counter_pkg.sv
// Shared timebase constants for the I2C master and its 2 MHz timing generator.
// The phase type and the counter-width helper live here as well.
package timing_counter_pkg;

  localparam int SYS_CLK_HZ      = 100_000_000;
  localparam int I2C_BASE_CLK_HZ = 2_000_000;
  localparam int I2C_BASE_DIV    = SYS_CLK_HZ / I2C_BASE_CLK_HZ;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_t;

  // Bits needed to count 0..max(hi,lo)-1; never narrower than one bit (DIV=2).
  function automatic int cnt_width(input int hi_cyc, input int lo_cyc);
    int m;
    m = (hi_cyc > lo_cyc) ? hi_cyc : lo_cyc;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/timing_counter_if.sv
// Timing outputs of the divider: the registered divided clock plus its edge strobes.
interface timing_counter_if;

  logic clk2mhz;
  logic rise_tick;
  logic fall_tick;

  modport master (output clk2mhz, output rise_tick, output fall_tick);
  modport slave  (input  clk2mhz, input  rise_tick, input  fall_tick);

endinterface

// File: rtl/timing_counter.sv
// Divides clk100mhz by DIV into a registered square wave with one-cycle rise/fall strobes.
// Odd DIV puts the extra cycle in the low phase.
module timing_counter
  import timing_counter_pkg::*;
#(
  parameter int IN_FREQ_HZ  = SYS_CLK_HZ,
  parameter int OUT_FREQ_HZ = I2C_BASE_CLK_HZ
) (
  input  logic             clk100mhz,
  input  logic             reset,
  timing_counter_if.master tmr
);

  localparam int DIV    = IN_FREQ_HZ / OUT_FREQ_HZ;
  localparam int HI_CYC = DIV / 2;
  localparam int LO_CYC = DIV - HI_CYC;
  localparam int CNT_W  = cnt_width(HI_CYC, LO_CYC);

  localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HI_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LO_CYC - 1);

  if ((OUT_FREQ_HZ <= 0) || (IN_FREQ_HZ % OUT_FREQ_HZ != 0) || (DIV < 2)) begin : g_bad_div
    $error("timing_counter: IN_FREQ_HZ/OUT_FREQ_HZ must be an integer >= 2");
  end

  phase_t           phase, phase_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise, rise_nxt;
  logic             fall, fall_nxt;

  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt + 1'b1;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (phase)
      PH_LO: begin
        if (cnt == LO_LAST) begin
          phase_nxt = PH_HI;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end
      end
      PH_HI: begin
        if (cnt == HI_LAST) begin
          phase_nxt = PH_LO;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end
      end
      default: begin
        phase_nxt = PH_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      phase <= PH_LO;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // All outputs are straight flop outputs; the phase encoding doubles as the clock level.
  assign tmr.clk2mhz   = phase;
  assign tmr.rise_tick = rise;
  assign tmr.fall_tick = fall;

endmodule

// File: tb/tb_timing_counter.sv
// Bench for timing_counter at DIV=50, 5 and 2, sharing one clock and reset.
module tb_timing_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  timing_counter_if if_main ();
  timing_counter_if if_d5 ();
  timing_counter_if if_d2 ();

  timing_counter #(.IN_FREQ_HZ(100_000_000), .OUT_FREQ_HZ(2_000_000)) u_main (
    .clk100mhz(clk), .reset(reset), .tmr(if_main.master));
  timing_counter #(.IN_FREQ_HZ(100_000_000), .OUT_FREQ_HZ(20_000_000)) u_d5 (
    .clk100mhz(clk), .reset(reset), .tmr(if_d5.master));
  timing_counter #(.IN_FREQ_HZ(100_000_000), .OUT_FREQ_HZ(50_000_000)) u_d2 (
    .clk100mhz(clk), .reset(reset), .tmr(if_d2.master));

  typedef struct {
    logic [2:0] m;
    logic [2:0] d5;
    logic [2:0] d2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  int   last_rise = -1;

  // Reference: after the k-th edge since reset, position in period decides everything.
  function automatic logic [2:0] model(input int div, input int kk);
    int lo, p;
    lo = div - div / 2;
    if (kk == 0) return 3'b000;
    p = kk % div;
    return {(p >= lo), (p == lo), (p == 0)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input logic rst_val);
    exp_t e;
    logic [2:0] om, o5, o2;
    reset = rst_val;
    @(posedge clk);
    if (rst_val) k = 0;
    else k++;
    e.m  = model(50, k);
    e.d5 = model(5, k);
    e.d2 = model(2, k);
    q.push_back(e);
    @(negedge clk);
    om = {if_main.clk2mhz, if_main.rise_tick, if_main.fall_tick};
    o5 = {if_d5.clk2mhz, if_d5.rise_tick, if_d5.fall_tick};
    o2 = {if_d2.clk2mhz, if_d2.rise_tick, if_d2.fall_tick};
    if (q.size() == 0) begin
      check("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = q.pop_front();
      check("main_outputs", {13'd0, om}, {13'd0, e.m});
      check("div5_outputs", {13'd0, o5}, {13'd0, e.d5});
      check("div2_outputs", {13'd0, o2}, {13'd0, e.d2});
    end
    check("main_ticks_exclusive", {15'd0, om[1] & om[0]}, 16'd0);
    if (om[1]) begin
      rise_cnt++;
      if (last_rise >= 0) check("main_period", 16'(k - last_rise), 16'd50);
      last_rise = k;
    end
    if (om[0]) fall_cnt++;
  endtask

  initial begin
    // Reset held for two cycles
    tick(1'b1);
    tick(1'b1);
    check("reset_cnt", {11'd0, u_main.cnt}, 16'd0);

    // Twelve full periods from reset release
    for (int i = 0; i < 600; i++) tick(1'b0);
    check("rise_count_12p", 16'(rise_cnt), 16'd12);
    check("fall_count_12p", 16'(fall_cnt), 16'd12);

    // Advance into the high phase to cnt=12, then pulse reset for one cycle
    for (int i = 0; i < 100 && (k % 50) != 37; i++) tick(1'b0);
    check("pre_reset_k_phase", 16'(k % 50), 16'd37);
    check("pre_reset_high", {15'd0, if_main.clk2mhz}, 16'd1);
    check("pre_reset_cnt", {11'd0, u_main.cnt}, 16'd12);
    last_rise = -1;
    tick(1'b1);
    check("mid_reset_cnt", {11'd0, u_main.cnt}, 16'd0);

    // Next rise must land exactly 25 edges after release
    rise_cnt = 0;
    for (int i = 0; i < 24; i++) tick(1'b0);
    check("no_rise_before_25", 16'(rise_cnt), 16'd0);
    tick(1'b0);
    check("rise_at_25", 16'(rise_cnt), 16'd1);
    for (int i = 0; i < 120; i++) tick(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
